// File: rtl/masked_xor_pipe_pkg.sv
// Shared helpers for the masked XOR pipeline: share slicing and mask reduction.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package masked_xor_pipe_pkg;

  // Upper bounds for the generic mask reduction below; WIDTH <= 32, SHARES <= 16.
  localparam int MAX_WIDTH    = 32;
  localparam int MAX_SHARES   = 16;
  localparam int MAX_RND_BITS = MAX_WIDTH * MAX_SHARES;

  typedef logic [MAX_WIDTH-1:0] share_vec_t;

  // LSB position of share idx inside a packed share vector.
  function automatic int share_lo(input int idx, input int width);
    return idx * width;
  endfunction

  // Total bits of a packed vector holding `shares` shares of `width` bits.
  function automatic int vec_bits(input int width, input int shares);
    return width * shares;
  endfunction

  // XOR of the first nsh width-bit shares of rnd, returned in the low `width` bits.
  function automatic share_vec_t share_xor_all(input logic [MAX_RND_BITS-1:0] rnd,
                                               input int width, input int nsh);
    share_vec_t acc;
    acc = '0;
    for (int s = 0; s < MAX_SHARES; s++) begin
      for (int b = 0; b < MAX_WIDTH; b++) begin
        if (s < nsh && b < width) acc[b] = acc[b] ^ rnd[s*width + b];
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/masked_xor_pipe_if.sv
// Handshake bundle for masked_xor_pipe: operand input, randomness feed, result output.
// Latency: n/a (wires only).
// Backpressure: valid/ready on each of the three channels.
//   master: producer/consumer side (drives operands, rnd, out_ready)
//   slave : the pipeline (drives in_ready, rnd_ready, out_valid, out_sh)
interface masked_xor_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int SHARES = 2
);
  logic                        in_valid;
  logic                        in_ready;
  logic [SHARES*WIDTH-1:0]     a_sh;
  logic [SHARES*WIDTH-1:0]     b_sh;
  logic [(SHARES-1)*WIDTH-1:0] rnd;
  logic                        rnd_valid;
  logic                        rnd_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic [SHARES*WIDTH-1:0]     out_sh;

  modport master (
    output in_valid, a_sh, b_sh, rnd, rnd_valid, out_ready,
    input  in_ready, rnd_ready, out_valid, out_sh
  );

  modport slave (
    input  in_valid, a_sh, b_sh, rnd, rnd_valid, out_ready,
    output in_ready, rnd_ready, out_valid, out_sh
  );
endinterface

// File: rtl/masked_xor_pipe_refresh_stage.sv
// Output register of the masked XOR pipe, optionally re-masking with fresh randomness.
// Latency: 1 cycle from S1 to out_sh.
// Backpressure: loads only when output is free (or draining) and randomness is available.
// Ports: clk/rst; s1_v/s1_dat from stage 1; rnd/rnd_valid/rnd_ready randomness feed;
//   out_valid/out_ready/out_sh result; rnd_cnt saturating refresh count; load = S2 loads now.
// Build option MASKED_XOR_REFRESH_EN enables the refresh; otherwise plain register.
module masked_xor_pipe_refresh_stage
  import masked_xor_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SHARES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s1_v,
  input  logic [SHARES*WIDTH-1:0]     s1_dat,
  input  logic [(SHARES-1)*WIDTH-1:0] rnd,
  input  logic                        rnd_valid,
  output logic                        rnd_ready,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [SHARES*WIDTH-1:0]     out_sh,
  output logic [CNT_W-1:0]            rnd_cnt,
  output logic                        load
);

  logic                    ref_ok;
  logic [SHARES*WIDTH-1:0] nxt_sh;

`ifdef MASKED_XOR_REFRESH_EN
  logic [WIDTH-1:0] mask_all;

  assign ref_ok    = rnd_valid;
  assign rnd_ready = load;
  assign mask_all  = WIDTH'(share_xor_all(MAX_RND_BITS'(rnd), WIDTH, SHARES-1));

  // Shares 0..SHARES-2 take their own mask; the last share takes the XOR of all
  // masks so the masks cancel and the unmasked value is preserved.
  always_comb begin
    nxt_sh = s1_dat;
    for (int i = 0; i < SHARES-1; i++) begin
      nxt_sh[share_lo(i, WIDTH) +: WIDTH] =
        s1_dat[share_lo(i, WIDTH) +: WIDTH] ^ rnd[share_lo(i, WIDTH) +: WIDTH];
    end
    nxt_sh[share_lo(SHARES-1, WIDTH) +: WIDTH] =
      s1_dat[share_lo(SHARES-1, WIDTH) +: WIDTH] ^ mask_all;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_cnt <= '0;
    end else if (load && (rnd_cnt != {CNT_W{1'b1}})) begin
      rnd_cnt <= rnd_cnt + 1'b1;
    end
  end
`else
  logic unused_rnd;

  assign ref_ok     = 1'b1;
  assign rnd_ready  = 1'b0;
  assign rnd_cnt    = '0;
  assign nxt_sh     = s1_dat;
  assign unused_rnd = ^{rnd, rnd_valid};
`endif

  // Gated by rst so no handshake is reported while the pipe is being cleared.
  assign load = !rst && s1_v && (!out_valid || out_ready) && ref_ok;

  // out_sh comes only from a register: no combinational path from rnd or operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sh    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_sh    <= nxt_sh;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/masked_xor_pipe.sv
// Pipelined share-wise XOR of two Boolean-masked operands with optional re-masking.
// Latency: 2 cycles in->out without stalls; 1 result per cycle.
// Backpressure: S1 holds while S2 is blocked; in_ready drops only when S1 is full and stuck.
// Ports: clk, rst (sync, active-high); bus (slave modport: in/rnd/out handshakes);
//   rnd_cnt = number of refreshes performed, saturating.
// Build option MASKED_XOR_REFRESH_EN: refresh S2 with rnd; undefined: plain S2 register.
module masked_xor_pipe
  import masked_xor_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SHARES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  masked_xor_pipe_if.slave    bus,
  output logic [CNT_W-1:0]    rnd_cnt
);

  localparam int VEC_W = vec_bits(WIDTH, SHARES);

  logic             s1_v;
  logic [VEC_W-1:0] s1_dat;
  logic             s2_load;

  // Accept when S1 is empty or is handing its beat to S2 in this same cycle.
  assign bus.in_ready = !rst && (!s1_v || s2_load);

  // Bitwise XOR of the packed vectors keeps share i paired with share i only.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_dat <= '0;
    end else if (bus.in_valid && bus.in_ready) begin
      s1_v   <= 1'b1;
      s1_dat <= bus.a_sh ^ bus.b_sh;
    end else if (s2_load) begin
      s1_v   <= 1'b0;
    end
  end

  masked_xor_pipe_refresh_stage #(
    .WIDTH  (WIDTH),
    .SHARES (SHARES),
    .CNT_W  (CNT_W)
  ) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .s1_v      (s1_v),
    .s1_dat    (s1_dat),
    .rnd       (bus.rnd),
    .rnd_valid (bus.rnd_valid),
    .rnd_ready (bus.rnd_ready),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_sh    (bus.out_sh),
    .rnd_cnt   (rnd_cnt),
    .load      (s2_load)
  );

endmodule

// File: tb/tb_masked_xor_pipe.sv
// Self-checking bench for masked_xor_pipe (8x2 instance plus a 4x3 instance with a tiny counter).
// Latency: n/a.
// Backpressure: exercised through out_ready and rnd_valid stalls.
module tb_masked_xor_pipe;

`ifdef MASKED_XOR_REFRESH_EN
  localparam bit REF = 1'b1;
`else
  localparam bit REF = 1'b0;
`endif

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int W3 = 4;
  localparam int S3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] rnd_cnt;
  logic [2:0]  rnd_cnt3;

  masked_xor_pipe_if #(.WIDTH(W),  .SHARES(S))  bus ();
  masked_xor_pipe_if #(.WIDTH(W3), .SHARES(S3)) bus3 ();

  masked_xor_pipe #(.WIDTH(W), .SHARES(S), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .rnd_cnt(rnd_cnt)
  );

  masked_xor_pipe #(.WIDTH(W3), .SHARES(S3), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .rnd_cnt(rnd_cnt3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int loads  = 0;
  int cyc    = 0;

  // Observed handshakes on the 8x2 instance, in order.
  logic [15:0] sent_q[$];
  logic [7:0]  rnd_q[$];
  logic [15:0] got_q[$];
  int          t_q[$];

  logic [15:0] va[0:31];
  logic [15:0] vb[0:31];
  int nbeats = 0;
  int nxt    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready)   sent_q.push_back(bus.a_sh ^ bus.b_sh);
      if (bus.rnd_valid && bus.rnd_ready) rnd_q.push_back(bus.rnd);
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_sh);
        t_q.push_back(cyc);
      end
    end
  end

  // Expected output shares from the share-wise XOR s = a^b and the mask r.
  function automatic logic [63:0] ref_out(input logic [63:0] s, input logic [63:0] r,
                                          input int w, input int n, input bit refresh);
    logic [63:0] o;
    logic [63:0] m;
    o = s;
    m = '0;
    if (refresh) begin
      for (int i = 0; i < n-1; i++) begin
        for (int b = 0; b < w; b++) begin
          o[i*w+b] = s[i*w+b] ^ r[i*w+b];
          m[b]     = m[b] ^ r[i*w+b];
        end
      end
      for (int b = 0; b < w; b++) o[(n-1)*w+b] = s[(n-1)*w+b] ^ m[b];
    end
    return o;
  endfunction

  // Unmasked value: XOR of all shares.
  function automatic logic [63:0] unmask(input logic [63:0] v, input int w, input int n);
    logic [63:0] u;
    u = '0;
    for (int i = 0; i < n; i++) for (int b = 0; b < w; b++) u[b] = u[b] ^ v[i*w+b];
    return u;
  endfunction

  // Drives pending beats va/vb[nxt], advancing on acceptance; fresh rnd every cycle.
  task automatic run_cycles(input int n);
    logic fire;
    for (int c = 0; c < n; c++) begin
      bus.in_valid = (nxt < nbeats);
      if (nxt < nbeats) begin
        bus.a_sh = va[nxt];
        bus.b_sh = vb[nxt];
      end
      bus.rnd = 8'($urandom);
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (fire) nxt++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_q();
    sent_q.delete(); rnd_q.delete(); got_q.delete(); t_q.delete();
    nxt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.rnd_ready !== 1'b0) begin errors++; $display("FAIL rst_rnd_ready got %b exp 0", bus.rnd_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_sh !== 16'h0) begin errors++; $display("FAIL rst_out_sh got %h exp 0000", bus.out_sh); end
    checks++; if (rnd_cnt !== 16'h0) begin errors++; $display("FAIL rst_rnd_cnt got %0d exp 0", rnd_cnt); end
    checks++; if (rnd_cnt3 !== 3'h0) begin errors++; $display("FAIL rst_rnd_cnt3 got %0d exp 0", rnd_cnt3); end
    loads = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_vector();
    logic [15:0] e;
    clear_q();
    e = 16'(ref_out(64'h96F0, 64'hA5, W, S, REF));
    bus.a_sh = 16'h550F; bus.b_sh = 16'hC3FF; bus.rnd = 8'hA5;
    bus.rnd_valid = 1'b1; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL vec_early_valid got %b exp 0", bus.out_valid); end
    @(posedge clk); #1;
    loads++;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL vec_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_sh !== e) begin errors++; $display("FAIL vec_out_sh got %h exp %h", bus.out_sh, e); end
    checks++; if (8'(unmask(64'(bus.out_sh), W, S)) !== 8'h66) begin errors++; $display("FAIL vec_unmask got %h exp 66", 8'(unmask(64'(bus.out_sh), W, S))); end
    checks++; if (rnd_cnt !== 16'(REF ? loads : 0)) begin errors++; $display("FAIL vec_rnd_cnt got %0d exp %0d", rnd_cnt, REF ? loads : 0); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL vec_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_stream();
    logic [15:0] e;
    logic [7:0]  rr;
    clear_q();
    for (int k = 0; k < 16; k++) begin va[k] = 16'($urandom); vb[k] = 16'($urandom); end
    nbeats = 16; bus.out_ready = 1'b1; bus.rnd_valid = 1'b1;
    run_cycles(16);
    checks++; if (nxt !== 16) begin errors++; $display("FAIL stream_accepted got %0d exp 16", nxt); end
    run_cycles(4);
    loads += 16;
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL stream_count got %0d exp 16", got_q.size()); end
    checks++; if (rnd_q.size() !== (REF ? 16 : 0)) begin errors++; $display("FAIL stream_rnd_used got %0d exp %0d", rnd_q.size(), REF ? 16 : 0); end
    if (t_q.size() == 16) begin
      checks++; if (t_q[15] - t_q[0] !== 15) begin errors++; $display("FAIL stream_throughput got %0d exp 15", t_q[15] - t_q[0]); end
    end
    for (int k = 0; k < got_q.size() && k < sent_q.size(); k++) begin
      rr = (rnd_q.size() > k) ? rnd_q[k] : 8'h00;
      e  = 16'(ref_out(64'(sent_q[k]), 64'(rr), W, S, REF));
      checks++; if (got_q[k] !== e) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", k, got_q[k], e); end
    end
    checks++; if (rnd_cnt !== 16'(REF ? loads : 0)) begin errors++; $display("FAIL stream_rnd_cnt got %0d exp %0d", rnd_cnt, REF ? loads : 0); end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    logic [15:0] e;
    logic [7:0]  rr;
    clear_q();
    for (int k = 0; k < 3; k++) begin va[k] = 16'($urandom); vb[k] = 16'($urandom); end
    nbeats = 3; bus.out_ready = 1'b0; bus.rnd_valid = 1'b1;
    run_cycles(3);
    held = bus.out_sh;
    run_cycles(2);
    checks++; if (nxt !== 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", nxt); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_sh !== held) begin errors++; $display("FAIL bp_stable got %h exp %h", bus.out_sh, held); end
    bus.out_ready = 1'b1;
    run_cycles(6);
    loads += 3;
    checks++; if (nxt !== 3) begin errors++; $display("FAIL bp_release_accepted got %0d exp 3", nxt); end
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < sent_q.size(); k++) begin
      rr = (rnd_q.size() > k) ? rnd_q[k] : 8'h00;
      e  = 16'(ref_out(64'(sent_q[k]), 64'(rr), W, S, REF));
      checks++; if (got_q[k] !== e) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", k, got_q[k], e); end
    end
  endtask

  task automatic test_rnd_stall();
    logic [15:0] e;
    logic [7:0]  rr;
    clear_q();
    va[0] = 16'($urandom); vb[0] = 16'($urandom);
    nbeats = 1; bus.out_ready = 1'b1; bus.rnd_valid = 1'b0;
    run_cycles(5);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.rnd_ready !== 1'b0) begin errors++; $display("FAIL stall_rnd_ready got %b exp 0", bus.rnd_ready); end
    checks++; if (got_q.size() !== (REF ? 0 : 1)) begin errors++; $display("FAIL stall_count got %0d exp %0d", got_q.size(), REF ? 0 : 1); end
    checks++; if (rnd_cnt !== 16'(REF ? loads : 0)) begin errors++; $display("FAIL stall_rnd_cnt got %0d exp %0d", rnd_cnt, REF ? loads : 0); end
    checks++; if (bus.in_ready !== !REF) begin errors++; $display("FAIL stall_in_ready got %b exp %b", bus.in_ready, !REF); end
    bus.rnd = 8'h3C; bus.rnd_valid = 1'b1;
    #1;
    checks++; if (bus.rnd_ready !== REF) begin errors++; $display("FAIL stall_release_rnd_ready got %b exp %b", bus.rnd_ready, REF); end
    @(posedge clk); #1;
    loads++;
    checks++; if (bus.out_valid !== REF) begin errors++; $display("FAIL stall_release_valid got %b exp %b", bus.out_valid, REF); end
    nbeats = 0;
    run_cycles(2);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL stall_final_count got %0d exp 1", got_q.size()); end
    if (got_q.size() == 1 && sent_q.size() == 1) begin
      rr = (rnd_q.size() > 0) ? rnd_q[0] : 8'h00;
      e  = 16'(ref_out(64'(sent_q[0]), 64'(rr), W, S, REF));
      checks++; if (got_q[0] !== e) begin errors++; $display("FAIL stall_data got %h exp %h", got_q[0], e); end
    end
    checks++; if (rnd_cnt !== 16'(REF ? loads : 0)) begin errors++; $display("FAIL stall_final_rnd_cnt got %0d exp %0d", rnd_cnt, REF ? loads : 0); end
  endtask

  task automatic test_reset_full();
    clear_q();
    for (int k = 0; k < 2; k++) begin va[k] = 16'($urandom); vb[k] = 16'($urandom); end
    nbeats = 2; bus.out_ready = 1'b0; bus.rnd_valid = 1'b1;
    run_cycles(3);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstfull_pre_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstfull_pre_in_ready got %b exp 0", bus.in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstfull_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.rnd_ready !== 1'b0) begin errors++; $display("FAIL rstfull_rnd_ready got %b exp 0", bus.rnd_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_sh !== 16'h0) begin errors++; $display("FAIL rstfull_out_sh got %h exp 0000", bus.out_sh); end
    checks++; if (rnd_cnt !== 16'h0) begin errors++; $display("FAIL rstfull_rnd_cnt got %0d exp 0", rnd_cnt); end
    rst = 1'b0; loads = 0;
    bus.out_ready = 1'b1; nbeats = 0; nxt = 0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstfull_post_in_ready got %b exp 1", bus.in_ready); end
    run_cycles(3);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rstfull_dropped got %0d exp 0", got_q.size()); end
  endtask

  task automatic test_three_share();
    logic [11:0] a;
    logic [11:0] b;
    logic [7:0]  r;
    logic [11:0] e;
    int          n_done;
    int          sat;
    n_done = 0;
    sat    = 7;
    for (int k = 0; k < 10; k++) begin
      a = 12'($urandom); b = 12'($urandom); r = 8'($urandom);
      e = 12'(ref_out(64'(a ^ b), 64'(r), W3, S3, REF));
      bus3.a_sh = a; bus3.b_sh = b; bus3.rnd = r;
      bus3.rnd_valid = 1'b1; bus3.out_ready = 1'b1; bus3.in_valid = 1'b1;
      @(negedge clk);
      checks++; if (bus3.in_ready !== 1'b1) begin errors++; $display("FAIL s3_in_ready[%0d] got %b exp 1", k, bus3.in_ready); end
      @(posedge clk); #1;
      bus3.in_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus3.rnd_ready !== REF) begin errors++; $display("FAIL s3_rnd_ready[%0d] got %b exp %b", k, bus3.rnd_ready, REF); end
      @(posedge clk); #1;
      n_done++;
      checks++; if (bus3.out_valid !== 1'b1) begin errors++; $display("FAIL s3_valid[%0d] got %b exp 1", k, bus3.out_valid); end
      checks++; if (bus3.out_sh !== e) begin errors++; $display("FAIL s3_data[%0d] got %h exp %h", k, bus3.out_sh, e); end
      checks++; if (4'(unmask(64'(bus3.out_sh), W3, S3)) !== 4'(unmask(64'(a ^ b), W3, S3))) begin
        errors++; $display("FAIL s3_unmask[%0d] got %h exp %h", k, 4'(unmask(64'(bus3.out_sh), W3, S3)), 4'(unmask(64'(a ^ b), W3, S3)));
      end
      @(posedge clk); #1;
    end
    checks++; if (rnd_cnt3 !== 3'(REF ? (n_done > sat ? sat : n_done) : 0)) begin
      errors++; $display("FAIL s3_rnd_cnt_sat got %0d exp %0d", rnd_cnt3, REF ? (n_done > sat ? sat : n_done) : 0);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a_sh = '0; bus.b_sh = '0; bus.rnd = '0;
    bus.rnd_valid = 1'b0; bus.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.a_sh = '0; bus3.b_sh = '0; bus3.rnd = '0;
    bus3.rnd_valid = 1'b0; bus3.out_ready = 1'b0;
    test_reset();
    test_vector();
    test_stream();
    test_backpressure();
    test_rnd_stall();
    test_reset_full();
    test_three_share();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
